// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t : 3-bit fetch FSM state encoding
//   FAULT_*       : 2-bit fault codes reported alongside each instruction
//   FETCH_NOP     : instruction substituted whenever a fetch faults
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } fetch_state_t;

    localparam logic [1:0]  FAULT_NONE     = 2'b00;
    localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
    localparam logic [1:0]  FAULT_ACCESS   = 2'b10;

    localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage sitting between program_counter and decode.
// Issues one instruction-memory read at a time for the current PC, captures
// the returned word (or a NOP plus fault code) and offers it to decode with a
// valid/ready handshake. pc_enable advances the PC once per consumed
// instruction or flush.
//
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   pc               : current PC from program_counter
//   pc_enable        : PC advance strobe (combinational)
//   flush            : redirect; kills the fetch in flight
//   imem_req_*       : read request (valid/ready, address)
//   imem_resp_*      : single-cycle read response (valid, data, error)
//   inst_valid/ready : handshake towards decode
//   inst, inst_pc    : instruction word and its PC
//   inst_fault       : 00 none, 01 misaligned, 10 access fault
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter logic [31:0] NOP  = FETCH_NOP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic            pc_enable,
    input  logic            flush,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            imem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [1:0]      inst_fault
);

    fetch_state_t state, state_next;

    logic        aligned;
    logic        capture_pc;
    logic        capture_inst;
    logic [31:0] inst_next;
    logic [1:0]  fault_next;

    assign aligned = (pc[1:0] == 2'b00);

    // Request and handshake outputs. The request stays up during a flush
    // so that an accepted request can be tracked into DROP.
    always_comb begin
        imem_req_valid = (state == ST_REQ) && aligned;
        imem_req_addr  = pc;
        inst_valid     = (state == ST_HOLD);
        pc_enable      = !reset && ((inst_valid && inst_ready) || flush);
    end

    always_comb begin
        state_next   = state;
        capture_pc   = 1'b0;
        capture_inst = 1'b0;
        inst_next    = NOP;
        fault_next   = FAULT_NONE;

        case (state)
            ST_IDLE: begin
                if (!flush) state_next = ST_REQ;
            end

            ST_REQ: begin
                if (aligned) begin
                    if (flush) begin
                        state_next = imem_req_ready ? ST_DROP : ST_IDLE;
                    end else if (imem_req_ready) begin
                        state_next = ST_WAIT;
                        capture_pc = 1'b1;
                    end
                end else begin
                    if (flush) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next   = ST_HOLD;
                        capture_pc   = 1'b1;
                        capture_inst = 1'b1;
                        inst_next    = NOP;
                        fault_next   = FAULT_MISALIGN;
                    end
                end
            end

            ST_WAIT: begin
                if (flush) begin
                    state_next = imem_resp_valid ? ST_REQ : ST_DROP;
                end else if (imem_resp_valid) begin
                    state_next   = ST_HOLD;
                    capture_inst = 1'b1;
                    inst_next    = imem_resp_err ? NOP : imem_resp_data;
                    fault_next   = imem_resp_err ? FAULT_ACCESS : FAULT_NONE;
                end
            end

            ST_HOLD: begin
                if (flush || inst_ready) state_next = ST_REQ;
            end

            ST_DROP: begin
                // A flush here still only waits for the outstanding response;
                // once it is discarded there is nothing left to drop.
                if (imem_resp_valid) state_next = ST_REQ;
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            inst       <= '0;
            inst_pc    <= '0;
            inst_fault <= FAULT_NONE;
        end else begin
            state <= state_next;
            if (capture_pc) inst_pc <= pc;
            if (capture_inst) begin
                inst       <= inst_next;
                inst_fault <= fault_next;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: each step drives inputs shortly
// after a rising edge and checks outputs before the next one.
module tb_instruction_fetch;

    localparam int unsigned XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] pc;
    logic            pc_enable;
    logic            flush;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            imem_resp_err;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic [1:0]      inst_fault;

    int errors = 0;
    int checks = 0;

    instruction_fetch #(.XLEN(XLEN)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .pc_enable       (pc_enable),
        .flush           (flush),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_fault      (inst_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset           = 1'b1;
        pc              = 64'h100;
        flush           = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_resp_err   = 1'b0;
        inst_ready      = 1'b1;

        tick(); tick();
        #1;
        check("rst_req_valid",  64'(imem_req_valid), 64'd0);
        check("rst_inst_valid", 64'(inst_valid),     64'd0);
        check("rst_pc_enable",  64'(pc_enable),      64'd0);
        check("rst_inst",       64'(inst),           64'd0);
        check("rst_inst_pc",    inst_pc,             64'd0);
        check("rst_fault",      64'(inst_fault),     64'd0);

        // Cycle 1 after release: IDLE
        reset = 1'b0;
        #1;
        check("idle_req_valid", 64'(imem_req_valid), 64'd0);

        // Cycle 2: REQ at 0x100, accepted
        tick(); #1;
        check("c2_req_valid", 64'(imem_req_valid), 64'd1);
        check("c2_req_addr",  imem_req_addr,       64'h100);

        // WAIT: response arrives one cycle after acceptance
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0050_0093;
        #1;
        check("wait_req_valid",  64'(imem_req_valid), 64'd0);
        check("wait_inst_valid", 64'(inst_valid),     64'd0);

        // HOLD: instruction presented and consumed
        tick();
        imem_resp_valid = 1'b0;
        #1;
        check("t1_inst_valid", 64'(inst_valid), 64'd1);
        check("t1_inst",       64'(inst),       64'h0050_0093);
        check("t1_inst_pc",    inst_pc,         64'h100);
        check("t1_fault",      64'(inst_fault), 64'd0);
        check("t1_pc_enable",  64'(pc_enable),  64'd1);

        // PC advanced; memory not ready for 3 cycles
        tick();
        pc             = 64'h104;
        imem_req_ready = 1'b0;
        #1;
        check("t1_pc_enable_once", 64'(pc_enable), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("stall_req_valid", 64'(imem_req_valid), 64'd1);
            check("stall_req_addr",  imem_req_addr,       64'h104);
            check("stall_pc_enable", 64'(pc_enable),      64'd0);
            if (i < 2) begin
                tick(); #1;
            end
        end
        imem_req_ready = 1'b1;

        // Accepted; response two cycles later, decode not ready
        tick();
        inst_ready = 1'b0;
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h00A0_0113;
        #1;
        check("wait2_inst_valid", 64'(inst_valid), 64'd0);
        tick();
        imem_resp_valid = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("hold_inst_valid", 64'(inst_valid), 64'd1);
            check("hold_inst",       64'(inst),       64'h00A0_0113);
            check("hold_inst_pc",    inst_pc,         64'h104);
            check("hold_pc_enable",  64'(pc_enable),  64'd0);
            tick(); #1;
        end
        inst_ready = 1'b1;
        #1;
        check("hold_release_pc_enable", 64'(pc_enable), 64'd1);

        // Misaligned PC: no request, NOP with misalign fault
        tick();
        pc = 64'h102;
        #1;
        check("mis_req_valid", 64'(imem_req_valid), 64'd0);
        tick(); #1;
        check("mis_inst_valid", 64'(inst_valid), 64'd1);
        check("mis_inst",       64'(inst),       64'h13);
        check("mis_fault",      64'(inst_fault), 64'd1);
        check("mis_inst_pc",    inst_pc,         64'h102);
        check("mis_pc_enable",  64'(pc_enable),  64'd1);

        // Access fault response
        tick();
        pc = 64'h108;
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_err   = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_err   = 1'b0;
        #1;
        check("err_inst_valid", 64'(inst_valid), 64'd1);
        check("err_inst",       64'(inst),       64'h13);
        check("err_fault",      64'(inst_fault), 64'd2);
        check("err_inst_pc",    inst_pc,         64'h108);

        // Flush in WAIT, response two cycles away
        tick();
        pc = 64'h10C;
        tick();
        flush = 1'b1;
        #1;
        check("flush_pc_enable", 64'(pc_enable), 64'd1);
        tick();
        flush = 1'b0;
        pc    = 64'h200;
        #1;
        check("drop_inst_valid", 64'(inst_valid),     64'd0);
        check("drop_req_valid",  64'(imem_req_valid), 64'd0);
        check("drop_pc_enable",  64'(pc_enable),      64'd0);
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1234_5678;
        #1;
        check("drop_late_inst_valid", 64'(inst_valid), 64'd0);
        tick();
        imem_resp_valid = 1'b0;
        #1;
        check("after_drop_inst_valid", 64'(inst_valid),     64'd0);
        check("after_drop_req_valid",  64'(imem_req_valid), 64'd1);
        check("after_drop_req_addr",   imem_req_addr,       64'h200);

        // Reset while WAIT
        tick();
        reset = 1'b1;
        flush = 1'b1;
        #1;
        check("rw_req_valid",  64'(imem_req_valid), 64'd0);
        check("rw_inst_valid", 64'(inst_valid),     64'd0);
        check("rw_pc_enable",  64'(pc_enable),      64'd0);
        check("rw_inst",       64'(inst),           64'd0);
        check("rw_inst_pc",    inst_pc,             64'd0);
        check("rw_fault",      64'(inst_fault),     64'd0);
        flush = 1'b0;
        tick();
        reset           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stale_inst_valid", 64'(inst_valid), 64'd0);
            check("stale_pc_enable",  64'(pc_enable),  64'd0);
            tick();
        end
        imem_resp_valid = 1'b0;
        #1;
        check("stale_req_valid", 64'(imem_req_valid), 64'd1);
        check("stale_req_addr",  imem_req_addr,       64'h200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the 64-bit RISC-V single-cycle CPU, directly downstream of `program_counter`. It takes the current PC and issues one instruction-memory read at a time. It captures the 32-bit instruction and presents it to decode with a valid/ready handshake. It also drives the PC `enable`, so the PC advances exactly once per instruction consumed or flush.

## Interface
- `XLEN`, 64, PC/address width.
- `NOP`, 32'h00000013, instruction substituted on any fault.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc`  in  XLEN  current PC from `program_counter`.
- `pc_enable`  out  1  drives `program_counter` enable; PC loads `pc_in` at the next edge.
- `flush`  in  1  redirect/kill; the current fetch is discarded.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  XLEN  request address, equal to `pc`.
- `imem_resp_valid`  in  1  response valid (single cycle).
- `imem_resp_data`  in  32  instruction word.
- `imem_resp_err`  in  1  access fault on this response.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode accepts the instruction.
- `inst`  out  32  instruction word.
- `inst_pc`  out  XLEN  PC of `inst`.
- `inst_fault`  out  2  00 none, 01 misaligned, 10 access fault.

## Operation
- States: IDLE, REQ, WAIT, HOLD, DROP. At most one request is outstanding.
- IDLE: no outputs asserted. Always moves to REQ at the next edge.
- REQ, `pc[1:0]==0`:
  - `imem_req_valid=1`, `imem_req_addr=pc`.
  - On handshake, latch `pc` into `inst_pc` and go to WAIT.
  - With no handshake, stay in REQ.
- REQ, `pc[1:0]!=0`:
  - No request is issued.
  - Load `inst=NOP`, `inst_fault=01`, `inst_pc=pc` and go to HOLD.
- WAIT: on `imem_resp_valid`, register `inst=imem_resp_data` and go to HOLD. If `imem_resp_err` is set, register `inst=NOP` and `inst_fault=10` instead.
- A response that arrives outside WAIT or DROP is a protocol violation and is ignored.
- HOLD: `inst_valid=1`, and `inst`, `inst_pc`, `inst_fault` hold stable. On `inst_valid && inst_ready`, go to REQ.
- `pc_enable = !reset && ((inst_valid && inst_ready) || flush)`. This output is combinational.
- Flush rules. Flush has priority over every other transition.
  - REQ with handshake in the same cycle → DROP.
  - REQ without handshake → IDLE. The request is withdrawn because `pc` is about to change.
  - WAIT with `imem_resp_valid` in the same cycle → REQ; the response is discarded.
  - WAIT with no response → DROP.
  - HOLD → REQ. The instruction is discarded, even if `inst_ready` is high.
  - DROP → stays in DROP.
  - IDLE → stays in IDLE.
- DROP: `inst_valid=0`. Wait for `imem_resp_valid`, discard the response, then go to REQ.

## Timing
- Reset (asynchronous, at any time, including with a request outstanding):
  - State becomes IDLE.
  - `inst`, `inst_pc`, `inst_fault` become 0.
  - `imem_req_valid`, `inst_valid`, `pc_enable` are 0.
  - Any memory response after reset deasserts is ignored.
  - First request: cycle 2 after reset release (IDLE, then REQ).
- Latency:
  - Request accepted in cycle N, response in cycle N+k (k≥1) → `inst_valid` in cycle N+k+1.
  - Misaligned PC → `inst_valid` in the cycle after REQ.
- Peak throughput is one instruction per 3 cycles (REQ, WAIT, HOLD).
- `pc` must be stable from REQ until the instruction is consumed. This holds because the only PC update is through `pc_enable`.

## Structure
- Shared package/header `fetch_pkg`:
  - state encoding, 3 bits
  - fault codes FAULT_NONE, FAULT_MISALIGN, FAULT_ACCESS
  - the NOP constant
- Single module with no sub-module. One state register, one output-capture register set, and combinational request/enable logic.

## Test plan
- Reset release with `pc=0x100`, `imem_req_ready=1`, response 1 cycle later with data 0x00500093, `inst_ready=1`:
  - `imem_req_addr=0x100` in cycle 2.
  - `inst=0x00500093`, `inst_pc=0x100`, `inst_fault=00`.
  - `pc_enable` high for exactly one cycle.
- `imem_req_ready` held low for 3 cycles: `imem_req_valid` stays high with `addr` stable, and there is no `pc_enable`.
- `inst_ready` low for 4 cycles in HOLD: `inst` and `inst_pc` hold their values, and `pc_enable` stays 0 until `inst_ready` rises.
- `pc=0x102`: no request is issued; `inst=0x00000013`, `inst_fault=01`, `inst_pc=0x102`.
- Response with `imem_resp_err=1`: `inst=NOP` and `inst_fault=10`.
- Flush in WAIT while the response is 2 cycles away:
  - `pc_enable=1` in the flush cycle.
  - The late response is dropped and `inst_valid` never asserts for it.
  - The next request uses the new `pc`.
- Reset asserted in WAIT: all outputs go to 0 immediately, and a stale response after release produces no `inst_valid`.
